multi_receiver_aggregator: RTL and testbench
============================================

Name: multi_receiver_aggregator

Overview:
Collects decoded BMC words from N_CH lighthouse receiver channels (one bmc_decoder per channel upstream) and merges them into one shared circular buffer. Each entry is tagged with channel ID and capture timestamp. A round-robin arbiter selects the channel written each cycle. Indexed readout and pop feed the host/SPI side; per-channel liveness watchdogs drive status outputs.

Parameters:
N_CH, 4, number of receiver channels (2..8)
DATA_W, 17, decoded word width
TS_W, 24, timestamp width
DEPTH, 32, buffer entries (power of two)
TIMEOUT, 9600000, cycles without data before a channel is declared dead (100 ms at 96 MHz)

Ports:
clk_96MHz  in  1  sole clock
reset  in  1  synchronous, active-high
decoded_data  in  N_CH*DATA_W  per-channel decoded words, channel i at [i*DATA_W +: DATA_W]
ts_last_data  in  N_CH*TS_W  per-channel capture timestamps
data_availible  in  N_CH  per-channel level: word valid, held until acknowledged
reset_bmc_decoder  out  N_CH  one-cycle acknowledge pulse per channel
block_wanted_number  in  $clog2(DEPTH)  read index, 0 = oldest entry
block_wanted  out  CH_W+DATA_W+TS_W  {ch_id, data, ts}; CH_W=max(1,$clog2(N_CH))
data_ready  out  1  block_wanted valid for the current index
pop  in  1  drop oldest entry
avl_blocks_nb  out  $clog2(DEPTH)+1  entries stored
overflow  out  N_CH  sticky: channel re-asserted while its holding slot was full
channel_alive  out  N_CH  watchdog status
state_led  out  1  OR of channel_alive

Behaviour:
- Reset (sync, high): wr/rd pointers=0, avl_blocks_nb=0, holding slots empty, reset_bmc_decoder=0, data_ready=0, block_wanted=0, overflow=0, channel_alive=0, watchdog counters=0, arbiter pointer=0.
- Capture: on each rising edge of data_availible[i] with slot i empty, latch {i, data, ts} into holding slot i. Pulse reset_bmc_decoder[i] the next cycle. Latency from edge to ack: 1 cycle.
- Rising edge while slot i is full: set overflow[i]. The word is not latched and no ack is issued. The decoder keeps holding the word and its ack is issued once the slot frees (re-sample the level).
- Arbiter: each cycle, if avl_blocks_nb<DEPTH, select the first full slot at or after the rr pointer (wrapping), write it at wr_ptr, empty the slot, and set the rr pointer to the winner+1 mod N_CH. At most one write per cycle.
- Full (count==DEPTH): no write. Slots stay full, which back-pressures the decoders through the withheld ack.
- Pop: if count>0, rd_ptr++. Pop when empty is ignored. Pop and write in the same cycle leave the count unchanged, and both pointers advance. A write into a just-freed slot at full+pop is permitted.
- Pointers wrap modulo DEPTH. The count is tracked separately, so full and empty are unambiguous.
- Readout registered, 1-cycle latency: block_wanted = mem[rd_ptr+index]. data_ready=1 iff index<count, sampled in the same cycle as the index. Otherwise block_wanted=0 and data_ready=0.
- Watchdog per channel: counter cleared and channel_alive[i] set on a capture for that channel. Otherwise the counter increments, saturating at TIMEOUT. Reaching TIMEOUT clears channel_alive[i].
- A reset mid-write discards buffer contents and holding slots. Decoders still holding words re-present them after reset.

Decomposition:
- Shared package/header: CH_W, ENTRY_W, and the entry field offsets (TS at [TS_W-1:0], data above it, ch_id at MSBs), used by the SPI readout block.
- One natural sub-module: rr_arbiter (N_CH request vector -> one-hot grant + index, rotating priority pointer).
- Buffer memory is inferred as RAM inside the top module.

Test Plan:
- Single word: ch2 asserts data=0x1ABCD, ts=0x000100 -> ack on ch2 1 cycle later; after pop-free readout index 0, block_wanted={2,0x1ABCD,0x000100}, data_ready=1, avl_blocks_nb=1.
- Simultaneous: all 4 channels assert in the same cycle -> entries written in order ch0,ch1,ch2,ch3 over 4 cycles; repeat with rr pointer=2 -> order 2,3,0,1.
- Full: fill 32 entries, then ch1 asserts -> no ack, count stays 32. Pop once -> ch1 written next cycle, ack follows, count returns to 32.
- Overflow: ch0 slot held full, data_availible[0] toggles low-high -> overflow[0]=1 and stays 1 until reset.
- Readout bounds: count=3, index=3 -> data_ready=0, block_wanted=0. Pop on empty -> count stays 0 and pointers are unchanged.
- Watchdog: TIMEOUT=100 in the test, one capture on ch3 -> channel_alive[3]=1 and state_led=1. After 100 idle cycles -> channel_alive[3]=0 and state_led=0.

Source files
------------

// File: rtl/multi_receiver_aggregator_pkg.sv
// multi_receiver_aggregator_pkg: default sizes, buffer entry layout {ch_id, data, ts} and channel-id width helper
package multi_receiver_aggregator_pkg;
   localparam int DEF_N_CH = 4;
   localparam int DEF_DATA_W = 17;
   localparam int DEF_TS_W = 24;
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int CH_W = ch_width(DEF_N_CH);
   localparam int ENTRY_W = CH_W + DEF_DATA_W + DEF_TS_W;
   localparam int TS_LSB = 0;
   localparam int DATA_LSB = DEF_TS_W;
   localparam int CH_LSB = DEF_TS_W + DEF_DATA_W;
endpackage

// File: rtl/multi_receiver_aggregator_rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter
//   clk, reset : clock and synchronous active-high reset
//   req        : request vector
//   advance    : a grant was consumed this cycle, move priority past the winner
//   grant, idx : one-hot grant and binary index of the winner
//   any        : at least one request present
module rr_arbiter
   import multi_receiver_aggregator_pkg::*;
#(
   parameter int N = 4,
   parameter int W = ch_width(N)
) (
   input logic clk,
   input logic reset,
   input logic [N-1:0] req,
   input logic advance,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic any
);
   logic [W-1:0] ptr;
   assign any = |req;
   // first pass picks the lowest request (wrap-around case), second overrides with the lowest at/after ptr
   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--) if (req[k]) idx = W'(k);
      for (int k = N - 1; k >= 0; k--) if (req[k] && k >= int'(ptr)) idx = W'(k);
   end
   always_comb begin
      grant = '0;
      for (int k = 0; k < N; k++) grant[k] = any && idx == W'(k);
   end
   always_ff @(posedge clk) begin
      if (reset) ptr <= '0;
      else if (advance && any) ptr <= (idx == W'(N - 1)) ? '0 : idx + W'(1);
   end
endmodule

// File: rtl/multi_receiver_aggregator.sv
// multi_receiver_aggregator: merges per-channel decoded words into one tagged circular buffer
//   clk_96MHz, reset          : clock and synchronous active-high reset
//   decoded_data, ts_last_data: per-channel word and capture timestamp
//   data_availible            : per-channel word-valid level, held until acknowledged
//   reset_bmc_decoder         : one-cycle acknowledge per channel
//   block_wanted_number       : read index, 0 = oldest
//   block_wanted, data_ready  : registered {ch_id, data, ts} and its validity
//   pop                       : drop oldest entry
//   avl_blocks_nb             : entries stored
//   overflow                  : sticky, channel re-asserted while its holding slot was full
//   channel_alive, state_led  : watchdog status per channel and their OR
module multi_receiver_aggregator
   import multi_receiver_aggregator_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int TS_W = DEF_TS_W,
   parameter int DEPTH = 32,
   parameter int TIMEOUT = 9600000,
   localparam int CW = ch_width(N_CH),
   localparam int AW = $clog2(DEPTH),
   localparam int EW = CW + DATA_W + TS_W
) (
   input logic clk_96MHz,
   input logic reset,
   input logic [N_CH*DATA_W-1:0] decoded_data,
   input logic [N_CH*TS_W-1:0] ts_last_data,
   input logic [N_CH-1:0] data_availible,
   output logic [N_CH-1:0] reset_bmc_decoder,
   input logic [AW-1:0] block_wanted_number,
   output logic [EW-1:0] block_wanted,
   output logic data_ready,
   input logic pop,
   output logic [AW:0] avl_blocks_nb,
   output logic [N_CH-1:0] overflow,
   output logic [N_CH-1:0] channel_alive,
   output logic state_led
);
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [N_CH-1:0] prev, pend, held, rise, cap, grant;
   logic [DATA_W-1:0] slot_d [N_CH];
   logic [TS_W-1:0] slot_t [N_CH];
   logic [WDW-1:0] wd [N_CH];
   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] win;
   logic any, room, do_pop, do_wr, in_range;
   assign room = avl_blocks_nb < (AW+1)'(DEPTH);
   assign do_pop = pop && avl_blocks_nb != '0;
   assign do_wr = any && (room || do_pop);
   assign rise = data_availible & ~prev;
   // a word is only taken (and acked) when the buffer can accept it; otherwise it stays pending
   // at the decoder and its still-held level is re-sampled once room appears
   assign cap = data_availible & (rise | pend) & ~held & {N_CH{room || do_pop}};
   assign in_range = {1'b0, block_wanted_number} < avl_blocks_nb;
   assign state_led = |channel_alive;
   rr_arbiter #(.N(N_CH), .W(CW)) u_arb (
      .clk(clk_96MHz),
      .reset(reset),
      .req(held),
      .advance(do_wr),
      .grant(grant),
      .idx(win),
      .any(any)
   );
   always_ff @(posedge clk_96MHz) if (do_wr) mem[wr_ptr] <= {win, slot_d[win], slot_t[win]};
   always_ff @(posedge clk_96MHz) begin
      for (int i = 0; i < N_CH; i++) begin
         if (cap[i]) begin
            slot_d[i] <= decoded_data[i*DATA_W +: DATA_W];
            slot_t[i] <= ts_last_data[i*TS_W +: TS_W];
         end
      end
   end
   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         prev <= '0;
         pend <= '0;
         held <= '0;
         reset_bmc_decoder <= '0;
         overflow <= '0;
         channel_alive <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         avl_blocks_nb <= '0;
         block_wanted <= '0;
         data_ready <= 1'b0;
         for (int i = 0; i < N_CH; i++) wd[i] <= '0;
      end else begin
         prev <= data_availible;
         pend <= (pend | rise) & ~cap & data_availible;
         held <= (held & ~(grant & {N_CH{do_wr}})) | cap;
         reset_bmc_decoder <= cap;
         overflow <= overflow | (rise & held);
         wr_ptr <= wr_ptr + AW'(do_wr);
         rd_ptr <= rd_ptr + AW'(do_pop);
         avl_blocks_nb <= avl_blocks_nb + (AW+1)'(do_wr) - (AW+1)'(do_pop);
         data_ready <= in_range;
         block_wanted <= in_range ? mem[rd_ptr + block_wanted_number] : '0;
         for (int i = 0; i < N_CH; i++) begin
            if (cap[i]) begin
               wd[i] <= '0;
               channel_alive[i] <= 1'b1;
            end else begin
               if (wd[i] != WDW'(TIMEOUT)) wd[i] <= wd[i] + WDW'(1);
               if (wd[i] == WDW'(TIMEOUT - 1)) channel_alive[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_receiver_aggregator.sv
// tb_multi_receiver_aggregator: directed self-checking bench for multi_receiver_aggregator
module tb_multi_receiver_aggregator;
   localparam int N = 4, DW = 17, TW = 24, EW = 43;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, pop, rdy, led;
   logic [N*DW-1:0] dd;
   logic [N*TW-1:0] ts;
   logic [N-1:0] av, ack, ovf, alive;
   logic [4:0] idx;
   logic [EW-1:0] bw;
   logic [5:0] avl;
   int n_chk = 0, n_fail = 0;
   int ord [4] = '{2, 3, 0, 1};
   multi_receiver_aggregator #(.TIMEOUT(100)) dut (
      .clk_96MHz(clk),
      .reset(reset),
      .decoded_data(dd),
      .ts_last_data(ts),
      .data_availible(av),
      .reset_bmc_decoder(ack),
      .block_wanted_number(idx),
      .block_wanted(bw),
      .data_ready(rdy),
      .pop(pop),
      .avl_blocks_nb(avl),
      .overflow(ovf),
      .channel_alive(alive),
      .state_led(led)
   );
   task automatic tick(input int c = 1);
      repeat (c) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic put(input int c, input int d, input int t);
      dd[c*DW +: DW] = 17'(d);
      ts[c*TW +: TW] = 24'(t);
   endtask
   function automatic logic [63:0] ent(input int c, input int d, input int t);
      return 64'({2'(c), 17'(d), 24'(t)});
   endfunction
   initial begin
      reset = 1'b1; dd = '0; ts = '0; av = '0; idx = '0; pop = 1'b0;
      tick(2);
      chk("rst_avl", 64'(avl), 64'(0));
      chk("rst_rdy", 64'(rdy), 64'(0));
      chk("rst_bw", 64'(bw), 64'(0));
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      chk("rst_alive", 64'(alive), 64'(0));
      reset = 1'b0;
      put(2, 'h1ABCD, 'h000100); av = 4'b0100; tick;
      chk("single_ack", 64'(ack), 64'(4'b0100));
      chk("single_cnt0", 64'(avl), 64'(0));
      av = '0; tick;
      chk("single_ack_end", 64'(ack), 64'(0));
      chk("single_cnt", 64'(avl), 64'(1));
      tick;
      chk("single_rdy", 64'(rdy), 64'(1));
      chk("single_bw", 64'(bw), ent(2, 'h1ABCD, 'h000100));
      chk("single_alive", 64'(alive), 64'(4'b0100));
      chk("single_led", 64'(led), 64'(1));
      pop = 1'b1; tick; pop = 1'b0;
      chk("single_pop", 64'(avl), 64'(0));
      reset = 1'b1; tick; reset = 1'b0;
      for (int i = 0; i < N; i++) put(i, 'h100 + i, 'h10 + i);
      av = 4'hF; tick;
      chk("sim_ack", 64'(ack), 64'(4'hF));
      av = '0; tick;
      chk("sim_cnt1", 64'(avl), 64'(1));
      tick(3);
      chk("sim_cnt4", 64'(avl), 64'(4));
      for (int k = 0; k < N; k++) begin
         idx = 5'(k); tick;
         chk($sformatf("sim_order%0d", k), 64'(bw), ent(k, 'h100 + k, 'h10 + k));
      end
      pop = 1'b1; tick(4); pop = 1'b0;
      chk("sim_drain", 64'(avl), 64'(0));
      put(1, 'h0AAAA, 'h5); av = 4'b0010; tick;
      av = '0; tick;
      pop = 1'b1; tick; pop = 1'b0;
      for (int i = 0; i < N; i++) put(i, 'h200 + i, 'h20 + i);
      av = 4'hF; tick;
      av = '0; tick(4);
      chk("rr2_cnt", 64'(avl), 64'(4));
      for (int k = 0; k < N; k++) begin
         idx = 5'(k); tick;
         chk($sformatf("rr2_order%0d", k), 64'(bw), ent(ord[k], 'h200 + ord[k], 'h20 + ord[k]));
      end
      pop = 1'b1; tick; pop = 1'b0;
      chk("bound_cnt3", 64'(avl), 64'(3));
      idx = 5'd3; tick;
      chk("bound_rdy", 64'(rdy), 64'(0));
      chk("bound_bw", 64'(bw), 64'(0));
      idx = 5'd2; tick;
      chk("bound_in_rdy", 64'(rdy), 64'(1));
      chk("bound_in_bw", 64'(bw), ent(1, 'h201, 'h21));
      pop = 1'b1; tick(3); pop = 1'b0;
      chk("drain_cnt", 64'(avl), 64'(0));
      pop = 1'b1; tick; pop = 1'b0;
      chk("pop_empty_cnt", 64'(avl), 64'(0));
      put(0, 'h1234, 'h55); av = 4'b0001; tick;
      av = '0; tick;
      idx = 5'd0; tick;
      chk("pop_empty_rdy", 64'(rdy), 64'(1));
      chk("pop_empty_bw", 64'(bw), ent(0, 'h1234, 'h55));
      chk("pop_empty_cnt1", 64'(avl), 64'(1));
      pop = 1'b1; tick; pop = 1'b0;
      for (int k = 0; k < 32; k++) begin
         put(0, k, k); av = 4'b0001; tick;
         av = '0; tick;
      end
      chk("full_cnt", 64'(avl), 64'(32));
      put(1, 'h1F00F, 'h777); av = 4'b0010; tick;
      chk("full_noack", 64'(ack), 64'(0));
      tick(3);
      chk("full_noack2", 64'(ack), 64'(0));
      chk("full_cnt_hold", 64'(avl), 64'(32));
      pop = 1'b1; tick; pop = 1'b0;
      chk("full_pop_ack", 64'(ack), 64'(4'b0010));
      chk("full_pop_cnt", 64'(avl), 64'(31));
      av = '0; tick;
      chk("full_refill", 64'(avl), 64'(32));
      chk("full_ack_end", 64'(ack), 64'(0));
      idx = 5'd31; tick;
      chk("full_newest", 64'(bw), ent(1, 'h1F00F, 'h777));
      idx = 5'd0; tick;
      chk("full_oldest", 64'(bw), ent(0, 1, 1));
      put(0, 'h11, 'h11); put(3, 'h33, 'h33); av = 4'b1001; tick;
      chk("ovf_none", 64'(ovf), 64'(0));
      pop = 1'b1; tick; pop = 1'b0;
      chk("ovf_ack", 64'(ack), 64'(4'b1001));
      av = '0; tick;
      chk("ovf_cnt", 64'(avl), 64'(32));
      av = 4'b0001; tick;
      chk("ovf_set", 64'(ovf), 64'(4'b0001));
      chk("ovf_noack", 64'(ack), 64'(0));
      av = '0; tick(3);
      chk("ovf_sticky", 64'(ovf), 64'(4'b0001));
      reset = 1'b1; tick; reset = 1'b0;
      chk("ovf_cleared", 64'(ovf), 64'(0));
      chk("wd_rst_alive", 64'(alive), 64'(0));
      chk("wd_rst_cnt", 64'(avl), 64'(0));
      put(3, 'h3, 'h3); av = 4'b1000; tick;
      chk("wd_alive", 64'(alive), 64'(4'b1000));
      chk("wd_led", 64'(led), 64'(1));
      av = '0; tick(99);
      chk("wd_alive99", 64'(alive), 64'(4'b1000));
      tick;
      chk("wd_dead", 64'(alive), 64'(0));
      chk("wd_led_off", 64'(led), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
